mem_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 14 +
 rtl/rr_arb2.sv | 21 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and FSM state encoding for the data-memory arbiter.
package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_valid,
    output logic       o_grant
);

    // Pure combinational pick; o_grant is the winning port index.
    always_comb begin
        o_valid = |i_req;
        o_grant = 1'b0;
        case (i_req)
            2'b01:   o_grant = 1'b0;
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = ~i_last_grant;
            default: o_grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a 32x8 single-port memory
// with a one-cycle registered read and a bidirectional data bus.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds it until
// ackN. Requests are only sampled in IDLE; everything is latched at the grant
// edge, so later changes on the request inputs have no effect on the
// transaction in flight. ackN is a single-cycle pulse; rdataN is valid while
// ackN=1 and otherwise holds its last read value. The requester drops reqN the
// cycle after ackN unless it wants another access.
module mem_arbiter #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic [1:0]        dbg_state
);
    import cpu_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic              r_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_last_grant;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_mem_we;
    logic              r_busy;

    logic              w_valid;
    logic              w_grant;
    logic              w_we_sel;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_wdata_sel;

    rr_arb2 u_rr (
        .i_req        ({req1, req0}),
        .i_last_grant (r_last_grant),
        .o_valid      (w_valid),
        .o_grant      (w_grant)
    );

    // Steer the winning requester's command fields toward the latch registers.
    always_comb begin
        w_we_sel    = w_grant ? we1    : we0;
        w_addr_sel  = w_grant ? addr1  : addr0;
        w_wdata_sel = w_grant ? wdata1 : wdata0;
    end

    // Next-state logic: writes skip WAIT because nothing has to come back.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = ACCESS;
            ACCESS:  w_next = r_we ? RESP : WAIT;
            WAIT:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Datapath and registered outputs, all derived from the next state so
    // they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_last_grant <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_mem_we     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy   <= (w_next != IDLE);
            r_ack0   <= (w_next == RESP) && !r_gnt;
            r_ack1   <= (w_next == RESP) &&  r_gnt;
            r_mem_we <= (r_state == IDLE) && w_valid && w_we_sel;
            if (r_state == IDLE && w_valid) begin
                r_gnt        <= w_grant;
                r_we         <= w_we_sel;
                r_addr       <= w_addr_sel;
                r_wdata      <= w_wdata_sel;
                r_last_grant <= w_grant;
            end
            if (r_state == WAIT) begin
                if (r_gnt) r_rdata1 <= mem_data;
                else       r_rdata0 <= mem_data;
            end
        end
    end

    // The memory drives the bus whenever write_en is low, so only drive it
    // during the write cycle.
    assign mem_data  = r_mem_we ? r_wdata : {DATA_W{1'bz}};

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign busy      = r_busy;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural 32x8 registered-read memory.
module tb_mem_arbiter;
    import cpu_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, mem_we;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [1:0]    dbg_state;
    wire  [DW-1:0] mem_data;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .dbg_state(dbg_state)
    );

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [32] = '{default: '0};
    logic [DW-1:0] mem_q = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end
    assign mem_data = mem_we ? {DW{1'bz}} : mem_q;

    // Bus watch: any unknown value means contention or a floating bus.
    int x_cycles = 0;
    always @(negedge clk) if (!rst && $isunknown(mem_data)) x_cycles++;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] model [32] = '{default: '0};
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete transaction on one port; latency counted in cycles from
    // the IDLE cycle in which req is raised (0 means it never completed).
    task automatic do_txn(input bit port, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output int lat,
                          output logic [DW-1:0] rd, output logic [DW-1:0] rd_other,
                          output int we_cycles, output logic [DW-1:0] bus_wr,
                          output bit other_ack);
        @(negedge clk);
        if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
        else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
        lat = 0; we_cycles = 0; bus_wr = '0; other_ack = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_we) begin we_cycles++; bus_wr = mem_data; end
            if (port ? ack0 : ack1) other_ack = 1'b1;
            if (port ? ack1 : ack0) begin lat = c; break; end
        end
        rd       = port ? rdata1 : rdata0;
        rd_other = port ? rdata0 : rdata1;
        if (port) req1 = 1'b0; else req0 = 1'b0;
        if (we) model[addr] = wd;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;     // requester's rdata at ack
        logic [DW-1:0] exp_other;  // other port's rdata at ack
    } vec_t;
    vec_t vecs[10];

    int            lat, wec, first0, first1, n, both, mism, rand_err;
    logic [DW-1:0] rd, rdo, bw, r0, exp_r1, e;
    bit            oack;
    int            order[8];

    initial begin
        vecs[0] = '{0, 1, 5'd3,  8'hA5, 8'h00, 8'h00};
        vecs[1] = '{0, 0, 5'd3,  8'h00, 8'hA5, 8'h00};
        vecs[2] = '{1, 1, 5'd31, 8'h5A, 8'h00, 8'hA5};
        vecs[3] = '{1, 0, 5'd31, 8'h00, 8'h5A, 8'hA5};
        vecs[4] = '{0, 0, 5'd0,  8'h00, 8'h00, 8'h5A};
        vecs[5] = '{1, 1, 5'd0,  8'hFF, 8'h5A, 8'h00};
        vecs[6] = '{0, 0, 5'd0,  8'h00, 8'hFF, 8'h5A};
        vecs[7] = '{1, 0, 5'd3,  8'h00, 8'hA5, 8'hFF};
        vecs[8] = '{0, 1, 5'd16, 8'hC3, 8'hFF, 8'hA5};
        vecs[9] = '{1, 0, 5'd16, 8'h00, 8'hC3, 8'hFF};

        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        check("rst_ack0",  32'(ack0), 32'd0);
        check("rst_ack1",  32'(ack1), 32'd0);
        check("rst_rdata0", 32'(rdata0), 32'd0);
        check("rst_rdata1", 32'(rdata1), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        // Directed single-port vectors.
        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wd, lat, rd, rdo, wec, bw, oack);
            check($sformatf("v%0d_lat", i), 32'(lat), vecs[i].we ? 32'd2 : 32'd3);
            check($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_other_rdata", i), 32'(rdo), 32'(vecs[i].exp_other));
            check($sformatf("v%0d_we_cycles", i), 32'(wec), vecs[i].we ? 32'd1 : 32'd0);
            if (vecs[i].we) check($sformatf("v%0d_bus", i), 32'(bw), 32'(vecs[i].wd));
            check($sformatf("v%0d_other_ack", i), 32'(oack), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_ack_pulse", i), 32'(vecs[i].port ? ack1 : ack0), 32'd0);
            check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
        end

        // Port 1 changes its request fields during ACCESS; latched read of 31 wins.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd31;
        @(negedge clk);
        addr1 = 5'd0; we1 = 1'b1; wdata1 = 8'h77;
        lat = 0; wec = 0;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (mem_we) wec++;
            if (ack1) begin lat = c; break; end
        end
        rd = rdata1;
        req1 = 1'b0; we1 = 1'b0;
        check("chg_lat", 32'(lat), 32'd3);
        check("chg_rdata1", 32'(rd), 32'(model[31]));
        check("chg_no_write", 32'(wec), 32'd0);

        // Simultaneous requests after reset: port 0 read first, then port 1 write.
        do_reset();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd7;
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'd7; wdata1 = 8'h3C;
        first0 = 0; first1 = 0; r0 = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (ack0 && first0 == 0) begin first0 = c; r0 = rdata0; req0 = 1'b0; end
            if (ack1 && first1 == 0) begin first1 = c; req1 = 1'b0; end
            if (first0 != 0 && first1 != 0) break;
        end
        req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        check("sim_ack0_cycle", 32'(first0), 32'd3);
        check("sim_ack1_cycle", 32'(first1), 32'd6);
        check("sim_rdata0", 32'(r0), 32'(model[7]));
        model[7] = 8'h3C;
        do_txn(0, 0, 5'd7, 8'h00, lat, rd, rdo, wec, bw, oack);
        check("sim_reread_lat", 32'(lat), 32'd3);
        check("sim_reread", 32'(rd), 32'h3C);

        // Sustained contention: strict alternation starting with port 0.
        do_reset();
        exp_r1 = '0; n = 0; both = 0; mism = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd16;
        for (int c = 1; c <= 80 && n < 8; c++) begin
            @(negedge clk);
            if (ack0 && ack1) both++;
            else if (ack0) begin
                order[n] = 0; n++;
                if (rdata1 !== exp_r1) mism++;
                if (rdata0 !== model[0]) mism++;
            end else if (ack1) begin
                order[n] = 1; n++;
                exp_r1 = model[16];
                if (rdata1 !== exp_r1) mism++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_count", 32'(n), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
        check("rr_both_ack", 32'(both), 32'd0);
        check("rr_rdata", 32'(mism), 32'd0);

        // Random traffic with a scoreboard queue for read data.
        rand_err = 0;
        repeat (50) begin
            bit            p, w;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            d = 8'($urandom_range(0, 255));
            if (!w) exp_q.push_back(model[a]);
            do_txn(p, w, a, d, lat, rd, rdo, wec, bw, oack);
            if (lat != (w ? 2 : 3)) rand_err++;
            if (oack) rand_err++;
            if (w && (wec != 1 || bw !== d)) rand_err++;
            if (!w) begin
                e = exp_q.pop_front();
                if (rd !== e) rand_err++;
            end
        end
        check("rand_errors", 32'(rand_err), 32'd0);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("bus_no_x", 32'(x_cycles), 32'd0);

        // Reset during the WAIT cycle of a read.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
        @(negedge clk);
        @(negedge clk);
        check("mid_in_wait", 32'(dbg_state), 32'(WAIT));
        rst = 1'b1;
        @(negedge clk);
        check("mid_state", 32'(dbg_state), 32'(IDLE));
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ack0", 32'(ack0), 32'd0);
        check("mid_ack1", 32'(ack1), 32'd0);
        check("mid_rdata0", 32'(rdata0), 32'd0);
        check("mid_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0; req0 = 1'b0;
        @(negedge clk);
        check("mid_no_late_ack", 32'(ack0), 32'd0);
        do_txn(0, 0, 5'd3, 8'h00, lat, rd, rdo, wec, bw, oack);
        check("mid_after_lat", 32'(lat), 32'd3);
        check("mid_after_rdata", 32'(rd), 32'(model[3]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
